// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with valid-qualified input,
// overlap/non-overlap modes and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_ERR  = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               detected_q, detected_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] hist_shift_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;
    logic               cfg_bad_s;

    // Ones in the low `len` positions; selects the compared window of hist/pattern.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // Candidate history/fill and match test for the bit currently offered.
    always_comb begin
        hist_shift_s = {hist_q[MAX_LEN-2:0], din};
        fill_inc_s   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        mask_s       = len_mask(len_q);
        match_s      = (fill_inc_s == len_q) &&
                       ((hist_shift_s & mask_s) == (pat_q & mask_s));
        cfg_bad_s    = (cfg_len == LEN_W'(0)) || (cfg_len > LEN_W'(MAX_LEN));
    end

    // Next-state, history, configuration and counter logic.
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        detected_d = 1'b0;
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        err_d      = err_q;
        count_d    = count_q;
        sat_d      = sat_q;

        if (cfg_load) begin
            // A bit offered alongside a config load is dropped on purpose.
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            err_d   = cfg_bad_s;
            hist_d  = '0;
            fill_d  = '0;
            state_d = cfg_bad_s ? ST_ERR : ST_FILL;
        end else begin
            case (state_q)
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                ST_FILL, ST_RUN: begin
                    if (din_valid) begin
                        hist_d     = hist_shift_s;
                        detected_d = match_s;
                        if (match_s && !ovl_q) begin
                            fill_d = '0;
                        end else begin
                            fill_d = fill_inc_s;
                        end
                        state_d = (fill_d == len_q) ? ST_RUN : ST_FILL;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            endcase
        end

        if (clr_count) begin
            count_d = '0;
        end else if (detected_d && !sat_q) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        sat_d = &count_d;
    end

    // State register with synchronous active-low reset to the default config.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            pat_q      <= DEF_PATTERN;
            len_q      <= LEN_W'(DEF_LEN);
            ovl_q      <= DEF_OVERLAP;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            detected_q <= detected_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            ovl_q      <= ovl_d;
            err_q      <= err_d;
        end
    end

    assign detected    = detected_q;
    assign match_count = count_q;
    assign count_sat   = sat_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (MAX_LEN=8, CNT_W=2); expectations hand-derived.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               clr_count = 1'b0;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
    logic               cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] s7_bits, s7_det;
    logic [5:0] s6_bits, s6_vld, s6_det;
    logic [3:0] s4_bits, s4_det;
    logic [4:0] exp_cnt [5];
    logic       exp_sat [5];

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count), .detected(detected),
        .match_count(match_count), .count_sat(count_sat), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic v, input logic exp_det, input string tag);
        din       = b;
        din_valid = v;
        tick();
        check(tag, {31'd0, detected}, {31'd0, exp_det});
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset defaults: pattern 1011, len 4, overlapping
        do_reset();
        check("rst_det", {31'd0, detected}, 32'd0);
        check("rst_cnt", {30'd0, match_count}, 32'd0);
        check("rst_sat", {31'd0, count_sat}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        s7_bits = 7'b1011011;
        s7_det  = 7'b0001001;
        for (int i = 6; i >= 0; i--) bit_in(s7_bits[i], 1'b1, s7_det[i], $sformatf("ovl_det%0d", 6 - i));
        check("ovl_cnt", {30'd0, match_count}, 32'd2);

        // Non-overlapping 1011
        do_reset();
        load(8'b0000_1011, 4'd4, 1'b0);
        check("nov_err", {31'd0, cfg_err}, 32'd0);
        s7_det = 7'b0001000;
        for (int i = 6; i >= 0; i--) bit_in(s7_bits[i], 1'b1, s7_det[i], $sformatf("nov_det%0d", 6 - i));
        check("nov_cnt1", {30'd0, match_count}, 32'd1);
        s4_bits = 4'b1011;
        s4_det  = 4'b0001;
        for (int i = 3; i >= 0; i--) bit_in(s4_bits[i], 1'b1, s4_det[i], $sformatf("nov2_det%0d", 3 - i));
        check("nov_cnt2", {30'd0, match_count}, 32'd2);

        // Valid gaps, pattern 110; count goes 2 -> 3 and saturates
        load(8'b0000_0110, 4'd3, 1'b1);
        check("gap_cnt_kept", {30'd0, match_count}, 32'd2);
        s6_bits = 6'b101100;
        s6_vld  = 6'b101001;
        s6_det  = 6'b000001;
        for (int i = 5; i >= 0; i--) bit_in(s6_bits[i], s6_vld[i], s6_det[i], $sformatf("gap_det%0d", 5 - i));
        check("gap_cnt", {30'd0, match_count}, 32'd3);
        check("gap_sat", {31'd0, count_sat}, 32'd1);

        // Mid-stream reset drops 1,0,1 so a following 1 must not complete 1011
        do_reset();
        bit_in(1'b1, 1'b1, 1'b0, "mid_a");
        bit_in(1'b0, 1'b1, 1'b0, "mid_b");
        bit_in(1'b1, 1'b1, 1'b0, "mid_c");
        do_reset();
        for (int i = 3; i >= 0; i--) bit_in(s4_bits[i], 1'b1, s4_det[i], $sformatf("mid_det%0d", 3 - i));

        // Saturation with len 1, non-overlap
        do_reset();
        load(8'b0000_0001, 4'd1, 1'b0);
        exp_cnt = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3};
        exp_sat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1, 1'b1, 1'b1, $sformatf("sat_det%0d", i));
            check($sformatf("sat_cnt%0d", i), {30'd0, match_count}, {27'd0, exp_cnt[i]});
            check($sformatf("sat_flag%0d", i), {31'd0, count_sat}, {31'd0, exp_sat[i]});
        end
        bit_in(1'b0, 1'b1, 1'b0, "len1_zero");
        clr_count = 1'b1;
        bit_in(1'b1, 1'b1, 1'b1, "clr_det");
        check("clr_cnt", {30'd0, match_count}, 32'd0);
        check("clr_sat", {31'd0, count_sat}, 32'd0);
        bit_in(1'b1, 1'b1, 1'b1, "post_clr_det");
        check("post_clr_cnt", {30'd0, match_count}, 32'd1);

        // Config errors: len 0 and len 9 disable detection
        load(8'b0000_0000, 4'd0, 1'b1);
        check("err_len0", {31'd0, cfg_err}, 32'd1);
        for (int i = 0; i < 4; i++) bit_in(i[0], 1'b1, 1'b0, $sformatf("err0_det%0d", i));
        load(8'b1111_1111, 4'd9, 1'b1);
        check("err_len9", {31'd0, cfg_err}, 32'd1);
        for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b1, 1'b0, $sformatf("err9_det%0d", i));
        check("err_cnt_kept", {30'd0, match_count}, 32'd1);
        load(8'b0000_1011, 4'd4, 1'b1);
        check("err_clear", {31'd0, cfg_err}, 32'd0);
        for (int i = 3; i >= 0; i--) bit_in(s4_bits[i], 1'b1, s4_det[i], $sformatf("resume_det%0d", 3 - i));
        check("resume_cnt", {30'd0, match_count}, 32'd2);

        // Load collision: the offered 1 is dropped and history cleared
        din       = 1'b1;
        din_valid = 1'b1;
        load(8'b0000_1011, 4'd4, 1'b1);
        check("col_det", {31'd0, detected}, 32'd0);
        check("col_cnt", {30'd0, match_count}, 32'd2);
        bit_in(1'b0, 1'b1, 1'b0, "col_a");
        bit_in(1'b1, 1'b1, 1'b0, "col_b");
        bit_in(1'b1, 1'b1, 1'b0, "col_c");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
